// File: rtl/fir_64_mdc_out_collector_if.sv
// Purpose: valid/ready stream bundle (data + byte strobe) used on both sides of the output collector.
// Latency: none, wires only.
// Backpressure: a beat transfers when valid and ready are both high; the source holds the beat until then.
interface fir_64_mdc_out_collector_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  // Source side drives the beat and watches ready
  modport master (
    output valid,
    output data,
    output strb,
    input  ready
  );

  // Sink side watches the beat and drives ready
  modport slave (
    input  valid,
    input  data,
    input  strb,
    output ready
  );

endinterface

// File: rtl/fir_64_mdc_out_collector.sv
// Purpose: collects exactly len output words per job from the engine, buffers them and forwards them to the streamer.
// Latency: an accepted input word is valid on the output one cycle later; one word per cycle sustained.
// Backpressure: input ready drops while the FIFO is full or once len words are taken; output holds until popped.

// Small synchronous FIFO with wrap-bit pointers; no bypass path, so a full FIFO never accepts a push.
module fir_64_mdc_out_collector_fifo #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          push_i,
  input  logic [DW-1:0] push_dat_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_dat_o,
  output logic          empty_o,
  output logic          full_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;
  logic [DW-1:0] mem_q [DEPTH];
  logic          do_push;
  logic          do_pop;

  // Pointers equal means empty; same index with opposite wrap bits means full
  assign empty_o    = (wptr_q == rptr_q);
  assign full_o     = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign head_dat_o = mem_q[rptr_q[AW-1:0]];

  // Guard locally so a misbehaving caller cannot corrupt the pointers
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointer and storage update; clear flushes pointers but leaves stale data in place
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (clear_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q[AW-1:0]] <= push_dat_i;
        wptr_q                <= wptr_q + PW'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + PW'(1);
      end
    end
  end

endmodule

module fir_64_mdc_out_collector #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  input  logic                      start_i,
  input  logic [CNT_WIDTH-1:0]      len_i,
  fir_64_mdc_out_collector_if.slave  y_V_i,
  fir_64_mdc_out_collector_if.master y_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [CNT_WIDTH-1:0]      cnt_o,
  output logic                      strb_err_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                state_q;
  state_e                state_d;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [CNT_WIDTH-1:0]  cnt_d;
  logic [CNT_WIDTH-1:0]  len_q;
  logic [CNT_WIDTH-1:0]  len_d;
  logic                  strb_err_q;
  logic                  strb_err_d;
  logic                  busy_q;
  logic                  done_q;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  in_rdy;
  logic                  in_xfer;
  logic                  out_xfer;

  // Input is open only while running, with room in the FIFO and words still owed for this job
  assign in_rdy   = (state_q == S_RUN) & ~fifo_full & (cnt_q != len_q);
  assign in_xfer  = y_V_i.valid & in_rdy;
  assign out_xfer = ~fifo_empty & y_o.ready;

  assign y_V_i.ready = in_rdy;
  assign y_o.valid   = ~fifo_empty;
  assign y_o.data    = fifo_head;
  assign y_o.strb    = '1;

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign cnt_o      = cnt_q;
  assign strb_err_o = strb_err_q;

  fir_64_mdc_out_collector_fifo #(
    .DW    (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (clear_i),
    .push_i     (in_xfer),
    .push_dat_i (y_V_i.data),
    .pop_i      (out_xfer),
    .head_dat_o (fifo_head),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full)
  );

  // Next-state for the job sequencer and its counters; clear wins over every other event
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    strb_err_d = strb_err_q;
    if (clear_i) begin
      state_d    = S_IDLE;
      cnt_d      = '0;
      strb_err_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            len_d      = len_i;
            cnt_d      = '0;
            strb_err_d = 1'b0;
            state_d    = (len_i != '0) ? S_RUN : S_DONE;
          end
        end
        S_RUN: begin
          if (in_xfer) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
            if (!(&y_V_i.strb)) begin
              strb_err_d = 1'b1;
            end
          end
          // cnt_q only equals len_q after the last word has already landed
          if (cnt_q == len_q) begin
            state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (fifo_empty) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Sequencer state plus registered status outputs derived from the next state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      strb_err_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      strb_err_q <= strb_err_d;
      busy_q     <= (state_d != S_IDLE);
      done_q     <= (state_d == S_DONE);
    end
  end

endmodule

// File: tb/tb_fir_64_mdc_out_collector.sv
// Purpose: self-checking bench for the output collector, scoreboarded against a job-level reference model.
// Latency: inputs driven on the falling edge, outputs observed 1ns later, handshakes resolve on the rising edge.
// Backpressure: output ready patterns are constant, stalled, or random per scenario.
module tb_fir_64_mdc_out_collector;

  typedef struct {
    logic [31:0] dat;
    logic [3:0]  strb;
  } word_t;

  logic        clk;
  logic        rst_n;
  logic        clear_i;
  logic        start_i;
  logic [15:0] len_i;
  logic        busy_o;
  logic        done_o;
  logic [15:0] cnt_o;
  logic        strb_err_o;

  fir_64_mdc_out_collector_if #(.DATA_WIDTH(32)) in_if ();
  fir_64_mdc_out_collector_if #(.DATA_WIDTH(32)) out_if ();

  fir_64_mdc_out_collector #(
    .DATA_WIDTH (32),
    .FIFO_DEPTH (4),
    .CNT_WIDTH  (16)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .clear_i    (clear_i),
    .start_i    (start_i),
    .len_i      (len_i),
    .y_V_i      (in_if),
    .y_o        (out_if),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .cnt_o      (cnt_o),
    .strb_err_o (strb_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  word_t       src_q[$];
  word_t       offered_q[$];
  word_t       acc_q[$];
  logic [31:0] got_q[$];
  word_t       exp_q[$];
  bit          exp_err;

  int cyc = 0;
  int start_cyc, done_cnt, done_cyc, last_pop_cyc, first_in_cyc, first_vld_cyc;
  int bad_cyc, err_rise_cyc;
  bit prev_err;
  bit busy_after_done;

  // Reference: a job forwards the first len offered words unchanged, flags any bad strobe among them
  task automatic model_job(input int len);
    exp_q.delete();
    exp_err = 1'b0;
    for (int i = 0; i < len && i < offered_q.size(); i++) begin
      exp_q.push_back(offered_q[i]);
      if (offered_q[i].strb != 4'hF) exp_err = 1'b1;
    end
  endtask

  // One clock: drive on the falling edge, observe, and log handshakes that fire on the next rising edge
  task automatic cycle(input bit rdy, input bit st, input bit clr, input logic [15:0] ln);
    @(negedge clk);
    start_i      = st;
    clear_i      = clr;
    len_i        = ln;
    out_if.ready = rdy;
    if (src_q.size() > 0) begin
      in_if.valid = 1'b1;
      in_if.data  = src_q[0].dat;
      in_if.strb  = src_q[0].strb;
    end else begin
      in_if.valid = 1'b0;
      in_if.data  = '0;
      in_if.strb  = 4'hF;
    end
    #1;
    if (cyc == done_cyc + 1) busy_after_done = busy_o;
    if (strb_err_o && !prev_err && err_rise_cyc < 0) err_rise_cyc = cyc;
    prev_err = strb_err_o;
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (out_if.valid && first_vld_cyc < 0) first_vld_cyc = cyc;
    if (in_if.valid && in_if.ready) begin
      if (first_in_cyc < 0) first_in_cyc = cyc;
      if (src_q[0].strb != 4'hF && bad_cyc < 0) bad_cyc = cyc;
      acc_q.push_back(src_q.pop_front());
    end
    if (out_if.valid && out_if.ready) begin
      got_q.push_back(out_if.data);
      last_pop_cyc = cyc;
      checks++;
      if (out_if.strb !== 4'hF) begin
        errors++;
        $display("FAIL out_strb cycle %0d got=%h exp=f", cyc, out_if.strb);
      end
    end
    cyc++;
  endtask

  task automatic job_start(input int len);
    acc_q.delete();
    got_q.delete();
    offered_q = src_q;
    done_cnt = 0;
    done_cyc = -10;
    last_pop_cyc = -1;
    first_in_cyc = -1;
    first_vld_cyc = -1;
    bad_cyc = -1;
    err_rise_cyc = -1;
    busy_after_done = 1'b1;
    start_cyc = cyc;
    cycle(1'b1, 1'b1, 1'b0, 16'(len));
  endtask

  // Runs until done (bounded); mode 0 = ready high, 1 = random ready; optional stray start at cycle restart_n
  task automatic job_finish(input int mode, input int restart_n);
    bit r;
    for (int n = 0; n < 600 && done_cnt == 0; n++) begin
      r = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      cycle(r, (n == restart_n), 1'b0, 16'd7);
    end
    if (done_cnt == 0) begin
      checks++;
      errors++;
      $display("FAIL job_timeout got=no_done exp=done_pulse");
    end
    cycle(1'b1, 1'b0, 1'b0, 16'd0);
    cycle(1'b1, 1'b0, 1'b0, 16'd0);
  endtask

  task automatic fill_src(input int n, input bit rnd);
    word_t w;
    src_q.delete();
    for (int i = 0; i < n; i++) begin
      w.dat  = rnd ? $urandom : 32'(i + 1);
      w.strb = 4'hF;
      src_q.push_back(w);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_i = 1'b0;
    start_i = 1'b0;
    len_i = '0;
    in_if.valid = 1'b0;
    in_if.data = '0;
    in_if.strb = 4'hF;
    out_if.ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", done_o); end
    checks++; if (cnt_o !== 16'd0) begin errors++; $display("FAIL rst_cnt got=%0d exp=0", cnt_o); end
    checks++; if (strb_err_o !== 1'b0) begin errors++; $display("FAIL rst_strb_err got=%b exp=0", strb_err_o); end
    checks++; if (out_if.valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_if.valid); end
    checks++; if (out_if.data !== 32'd0) begin errors++; $display("FAIL rst_out_data got=%h exp=0", out_if.data); end
    checks++; if (in_if.ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b exp=0", in_if.ready); end
  endtask

  task automatic test_basic();
    fill_src(8, 1'b0);
    job_start(8);
    cycle(1'b1, 1'b0, 1'b0, 16'd0);
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL basic_busy_after_start got=%b exp=1", busy_o); end
    checks++; if (in_if.ready !== 1'b1) begin errors++; $display("FAIL basic_ready_after_start got=%b exp=1", in_if.ready); end
    job_finish(0, -1);
    model_job(8);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_words got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++; if (got_q[i] !== exp_q[i].dat) begin errors++; $display("FAIL basic_data[%0d] got=%h exp=%h", i, got_q[i], exp_q[i].dat); end
    end
    checks++; if (first_vld_cyc != first_in_cyc + 1) begin errors++; $display("FAIL basic_latency got=%0d exp=%0d", first_vld_cyc, first_in_cyc + 1); end
    checks++; if (cnt_o !== 16'd8) begin errors++; $display("FAIL basic_cnt got=%0d exp=8", cnt_o); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt); end
    checks++; if (strb_err_o !== 1'b0) begin errors++; $display("FAIL basic_strb_err got=%b exp=0", strb_err_o); end
    checks++; if (busy_after_done !== 1'b0) begin errors++; $display("FAIL basic_busy_fall got=%b exp=0", busy_after_done); end
  endtask

  task automatic test_backpressure();
    fill_src(10, 1'b0);
    job_start(10);
    repeat (6) cycle(1'b0, 1'b0, 1'b0, 16'd0);
    checks++; if (acc_q.size() != 4) begin errors++; $display("FAIL bp_accepted_while_stalled got=%0d exp=4", acc_q.size()); end
    checks++; if (in_if.ready !== 1'b0) begin errors++; $display("FAIL bp_ready_when_full got=%b exp=0", in_if.ready); end
    job_finish(0, -1);
    model_job(10);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_words got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++; if (got_q[i] !== exp_q[i].dat) begin errors++; $display("FAIL bp_data[%0d] got=%h exp=%h", i, got_q[i], exp_q[i].dat); end
    end
    checks++; if (!(done_cyc > last_pop_cyc)) begin errors++; $display("FAIL bp_done_after_pop got=%0d exp>%0d", done_cyc, last_pop_cyc); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done_pulses got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_excess();
    fill_src(12, 1'b1);
    job_start(5);
    job_finish(0, -1);
    model_job(5);
    checks++; if (acc_q.size() != 5) begin errors++; $display("FAIL excess_accepted got=%0d exp=5", acc_q.size()); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL excess_words got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++; if (got_q[i] !== exp_q[i].dat) begin errors++; $display("FAIL excess_data[%0d] got=%h exp=%h", i, got_q[i], exp_q[i].dat); end
    end
    checks++; if (in_if.ready !== 1'b0) begin errors++; $display("FAIL excess_ready got=%b exp=0", in_if.ready); end
    checks++; if (in_if.valid !== 1'b1 || in_if.data !== offered_q[5].dat) begin
      errors++; $display("FAIL excess_sixth_held got=%b/%h exp=1/%h", in_if.valid, in_if.data, offered_q[5].dat);
    end
    src_q.delete();
  endtask

  task automatic test_zero_and_restart();
    fill_src(3, 1'b1);
    job_start(0);
    job_finish(0, -1);
    checks++; if (done_cyc != start_cyc + 1) begin errors++; $display("FAIL zero_done_cycle got=%0d exp=%0d", done_cyc, start_cyc + 1); end
    checks++; if (acc_q.size() != 0) begin errors++; $display("FAIL zero_accepted got=%0d exp=0", acc_q.size()); end
    checks++; if (busy_after_done !== 1'b0) begin errors++; $display("FAIL zero_idle got=%b exp=0", busy_after_done); end
    fill_src(6, 1'b1);
    job_start(3);
    job_finish(0, 1);
    model_job(3);
    checks++; if (cnt_o !== 16'd3) begin errors++; $display("FAIL restart_cnt got=%0d exp=3", cnt_o); end
    checks++; if (got_q.size() != 3) begin errors++; $display("FAIL restart_words got=%0d exp=3", got_q.size()); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL restart_done_pulses got=%0d exp=1", done_cnt); end
    src_q.delete();
  endtask

  task automatic test_strobe_error();
    fill_src(4, 1'b1);
    src_q[2].strb = 4'h3;
    job_start(4);
    job_finish(0, -1);
    model_job(4);
    checks++; if (err_rise_cyc != bad_cyc + 1) begin errors++; $display("FAIL strb_err_rise got=%0d exp=%0d", err_rise_cyc, bad_cyc + 1); end
    checks++; if (strb_err_o !== exp_err) begin errors++; $display("FAIL strb_err_sticky got=%b exp=%b", strb_err_o, exp_err); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++; if (got_q[i] !== exp_q[i].dat) begin errors++; $display("FAIL strb_data[%0d] got=%h exp=%h", i, got_q[i], exp_q[i].dat); end
    end
    fill_src(2, 1'b1);
    job_start(2);
    job_finish(0, -1);
    checks++; if (strb_err_o !== 1'b0) begin errors++; $display("FAIL strb_err_cleared got=%b exp=0", strb_err_o); end
  endtask

  task automatic test_random_jobs();
    int len;
    for (int j = 0; j < 4; j++) begin
      len = $urandom_range(1, 20);
      fill_src(len + $urandom_range(0, 3), 1'b1);
      foreach (src_q[i]) if ($urandom_range(0, 7) == 0) src_q[i].strb = 4'($urandom_range(0, 14));
      job_start(len);
      job_finish(1, -1);
      model_job(len);
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d_words got=%0d exp=%0d", j, got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got_q.size()) begin
        checks++; if (got_q[i] !== exp_q[i].dat) begin errors++; $display("FAIL rand%0d_data[%0d] got=%h exp=%h", j, i, got_q[i], exp_q[i].dat); end
      end
      checks++; if (cnt_o !== 16'(len)) begin errors++; $display("FAIL rand%0d_cnt got=%0d exp=%0d", j, cnt_o, len); end
      checks++; if (strb_err_o !== exp_err) begin errors++; $display("FAIL rand%0d_strb_err got=%b exp=%b", j, strb_err_o, exp_err); end
      src_q.delete();
    end
  endtask

  task automatic test_clear_and_reset();
    int n;
    fill_src(8, 1'b1);
    job_start(8);
    n = 0;
    while (acc_q.size() < 3 && n < 50) begin
      cycle(1'b0, 1'b0, 1'b0, 16'd0);
      n++;
    end
    src_q.delete();
    cycle(1'b0, 1'b1, 1'b1, 16'd5);
    repeat (4) cycle(1'b1, 1'b0, 1'b0, 16'd0);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL clear_busy got=%b exp=0", busy_o); end
    checks++; if (out_if.valid !== 1'b0) begin errors++; $display("FAIL clear_fifo_empty got=%b exp=0", out_if.valid); end
    checks++; if (cnt_o !== 16'd0) begin errors++; $display("FAIL clear_cnt got=%0d exp=0", cnt_o); end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL clear_no_done got=%0d exp=0", done_cnt); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL clear_no_output got=%0d exp=0", got_q.size()); end

    fill_src(4, 1'b1);
    job_start(4);
    n = 0;
    while (acc_q.size() < 4 && n < 50) begin
      cycle(1'b0, 1'b0, 1'b0, 16'd0);
      n++;
    end
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 16'd0);
    checks++; if (busy_o !== 1'b1 || out_if.valid !== 1'b1) begin
      errors++; $display("FAIL drain_setup got=%b/%b exp=1/1", busy_o, out_if.valid);
    end
    rst_n = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL arst_busy got=%b exp=0", busy_o); end
    checks++; if (cnt_o !== 16'd0) begin errors++; $display("FAIL arst_cnt got=%0d exp=0", cnt_o); end
    checks++; if (out_if.valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid got=%b exp=0", out_if.valid); end
    checks++; if (out_if.data !== 32'd0) begin errors++; $display("FAIL arst_out_data got=%h exp=0", out_if.data); end
    checks++; if (in_if.ready !== 1'b0) begin errors++; $display("FAIL arst_in_ready got=%b exp=0", in_if.ready); end
    checks++; if (done_o !== 1'b0 || strb_err_o !== 1'b0) begin errors++; $display("FAIL arst_flags got=%b/%b exp=0/0", done_o, strb_err_o); end
    src_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    prev_err = 1'b0;
    done_cyc = -10;
    test_reset();
    test_basic();
    test_backpressure();
    test_excess();
    test_zero_and_restart();
    test_strobe_error();
    test_random_jobs();
    test_clear_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
